// File: rtl/alarm_ctrl_multi.sv
// Multi-alarm clock control FSM: time/alarm editing, ringing, bounded snooze
// and ring auto-timeout. All outputs are registered.
module alarm_ctrl_multi #(
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int SNOOZE_MAX       = 3,
  parameter int RING_TIMEOUT_MIN = 10,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  SetTime,
  input  logic                  SetAlarm,
  input  logic                  Next,
  input  logic                  Up,
  input  logic                  Snooze,
  input  logic                  Stop,
  input  logic                  MinTick,
  input  logic [NUM_ALARMS-1:0] Match,
  output logic [1:0]            SEL,
  output logic                  INCR,
  output logic                  Clear,
  output logic                  LD_TIME,
  output logic                  LD_ALARM,
  output logic [AW-1:0]         ALM_IDX,
  output logic [NUM_ALARMS-1:0] AlarmEn,
  output logic                  Ring,
  output logic [AW-1:0]         RingIdx
);

  localparam int CNT_TOP = (SNOOZE_MIN > RING_TIMEOUT_MIN) ? SNOOZE_MIN : RING_TIMEOUT_MIN;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam int SCW     = (SNOOZE_MAX > 0) ? $clog2(SNOOZE_MAX + 1) : 1;

  typedef enum logic [2:0] {IDLE, T_EDIT, A_SEL, A_EDIT, RING, SNOOZE} state_t;

  state_t                  state, state_n;
  logic                    nx_q, up_q, sz_q, sp_q;
  logic                    nx_p, up_p, sz_p, sp_p;
  logic [CW-1:0]           cnt, cnt_n;
  logic [SCW-1:0]          scnt, scnt_n;
  logic                    pend, pend_n;
  logic [AW-1:0]           pend_idx, pend_idx_n;
  logic [1:0]              sel_n;
  logic                    incr_n, clr_n, ldt_n, lda_n;
  logic [AW-1:0]           idx_n, ridx_n;
  logic [NUM_ALARMS-1:0]   en_n, hit, hit_other, ring_mask;
  logic                    qual, qual_other;

  function automatic logic [AW-1:0] lowest(input logic [NUM_ALARMS-1:0] v);
    lowest = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++)
      if (v[NUM_ALARMS-1-i]) lowest = AW'(NUM_ALARMS - 1 - i);
  endfunction

  assign nx_p = Next & ~nx_q;
  assign up_p = Up & ~up_q;
  assign sz_p = Snooze & ~sz_q;
  assign sp_p = Stop & ~sp_q;

  assign hit        = Match & AlarmEn;
  assign qual       = MinTick & (|hit);
  assign ring_mask  = NUM_ALARMS'(1) << RingIdx;
  assign hit_other  = hit & ~ring_mask;
  assign qual_other = MinTick & (|hit_other);

  assign Ring = (state == RING);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      nx_q     <= 1'b0;
      up_q     <= 1'b0;
      sz_q     <= 1'b0;
      sp_q     <= 1'b0;
      cnt      <= '0;
      scnt     <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
      SEL      <= '0;
      INCR     <= 1'b0;
      Clear    <= 1'b0;
      LD_TIME  <= 1'b0;
      LD_ALARM <= 1'b0;
      ALM_IDX  <= '0;
      AlarmEn  <= '0;
      RingIdx  <= '0;
    end else begin
      state    <= state_n;
      nx_q     <= Next;
      up_q     <= Up;
      sz_q     <= Snooze;
      sp_q     <= Stop;
      cnt      <= cnt_n;
      scnt     <= scnt_n;
      pend     <= pend_n;
      pend_idx <= pend_idx_n;
      SEL      <= sel_n;
      INCR     <= incr_n;
      Clear    <= clr_n;
      LD_TIME  <= ldt_n;
      LD_ALARM <= lda_n;
      ALM_IDX  <= idx_n;
      AlarmEn  <= en_n;
      RingIdx  <= ridx_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    scnt_n     = scnt;
    pend_n     = pend;
    pend_idx_n = pend_idx;
    sel_n      = SEL;
    incr_n     = 1'b0;
    clr_n      = 1'b0;
    ldt_n      = 1'b0;
    lda_n      = 1'b0;
    idx_n      = ALM_IDX;
    en_n       = AlarmEn;
    ridx_n     = RingIdx;

    // Matches seen while editing are remembered (first slot wins) and serviced in IDLE.
    if ((state == T_EDIT || state == A_SEL || state == A_EDIT) && qual && !pend) begin
      pend_n     = 1'b1;
      pend_idx_n = lowest(hit);
    end

    unique case (state)
      IDLE: begin
        if (qual || pend) begin
          state_n = RING;
          ridx_n  = qual ? lowest(hit) : pend_idx;
          pend_n  = 1'b0;
          cnt_n   = CW'(RING_TIMEOUT_MIN);
          scnt_n  = '0;
        end else if (SetTime) begin
          state_n = T_EDIT;
          sel_n   = 2'd0;
          clr_n   = 1'b1;
        end else if (SetAlarm) begin
          state_n = A_SEL;
        end
      end
      T_EDIT: begin
        if (!SetTime) begin
          state_n = IDLE;
        end else if (nx_p) begin
          if (SEL == 2'd2) begin
            ldt_n   = 1'b1;
            state_n = IDLE;
          end else begin
            sel_n = SEL + 2'd1;
          end
        end else if (up_p) begin
          incr_n = 1'b1;
        end
      end
      A_SEL: begin
        if (!SetAlarm) begin
          state_n = IDLE;
        end else if (nx_p) begin
          state_n = A_EDIT;
          sel_n   = 2'd0;
          clr_n   = 1'b1;
        end else if (up_p) begin
          idx_n = (int'(ALM_IDX) == NUM_ALARMS - 1) ? '0 : ALM_IDX + AW'(1);
        end else if (sp_p) begin
          en_n[ALM_IDX] = 1'b0;
        end
      end
      A_EDIT: begin
        if (!SetAlarm) begin
          state_n = IDLE;
        end else if (nx_p) begin
          if (SEL == 2'd0) begin
            sel_n = 2'd1;
          end else begin
            lda_n         = 1'b1;
            en_n[ALM_IDX] = 1'b1;
            state_n       = A_SEL;
          end
        end else if (up_p) begin
          incr_n = 1'b1;
        end
      end
      RING: begin
        // An ignored snooze falls through so the timeout still counts down.
        if (sp_p) begin
          state_n = IDLE;
          scnt_n  = '0;
        end else if (sz_p && (scnt < SCW'(SNOOZE_MAX))) begin
          state_n = SNOOZE;
          scnt_n  = scnt + SCW'(1);
          cnt_n   = CW'(SNOOZE_MIN);
        end else if (MinTick) begin
          if (cnt <= CW'(1)) begin
            state_n = IDLE;
            scnt_n  = '0;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
      SNOOZE: begin
        if (sp_p) begin
          state_n = IDLE;
          scnt_n  = '0;
        end else if (qual_other) begin
          state_n = RING;
          ridx_n  = lowest(hit_other);
          scnt_n  = '0;
          cnt_n   = CW'(RING_TIMEOUT_MIN);
        end else if (MinTick) begin
          if (cnt <= CW'(1)) begin
            state_n = RING;
            cnt_n   = CW'(RING_TIMEOUT_MIN);
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Bench for alarm_ctrl_multi: table of per-cycle vectors plus hand sequences,
// expected outputs queued at drive time and compared one cycle later.
module tb_alarm_ctrl_multi;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       SetTime, SetAlarm, Next, Up, Snooze, Stop, MinTick;
  logic [3:0] Match;
  logic [1:0] SEL;
  logic       INCR, Clear, LD_TIME, LD_ALARM, Ring;
  logic [1:0] ALM_IDX, RingIdx;
  logic [3:0] AlarmEn;

  alarm_ctrl_multi #(
    .NUM_ALARMS(4),
    .SNOOZE_MIN(2),
    .SNOOZE_MAX(3),
    .RING_TIMEOUT_MIN(10)
  ) dut (
    .Clk(Clk), .Reset(Reset), .SetTime(SetTime), .SetAlarm(SetAlarm),
    .Next(Next), .Up(Up), .Snooze(Snooze), .Stop(Stop), .MinTick(MinTick),
    .Match(Match), .SEL(SEL), .INCR(INCR), .Clear(Clear), .LD_TIME(LD_TIME),
    .LD_ALARM(LD_ALARM), .ALM_IDX(ALM_IDX), .AlarmEn(AlarmEn), .Ring(Ring),
    .RingIdx(RingIdx)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       incr, clr, ldt, lda;
    logic [1:0] idx;
    logic [3:0] en;
    logic       ring;
    logic [1:0] ridx;
  } out_t;

  typedef struct packed {
    logic [6:0] b;
    logic [3:0] m;
  } in_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  localparam logic [6:0] I_NO = 7'b0000000;
  localparam logic [6:0] I_ST = 7'b1000000;
  localparam logic [6:0] I_SA = 7'b0100000;
  localparam logic [6:0] I_NX = 7'b0010000;
  localparam logic [6:0] I_UP = 7'b0001000;
  localparam logic [6:0] I_SZ = 7'b0000100;
  localparam logic [6:0] I_SP = 7'b0000010;
  localparam logic [6:0] I_MT = 7'b0000001;
  localparam logic [3:0] S_NO  = 4'b0000;
  localparam logic [3:0] S_INC = 4'b1000;
  localparam logic [3:0] S_CLR = 4'b0100;
  localparam logic [3:0] S_LDT = 4'b0010;
  localparam logic [3:0] S_LDA = 4'b0001;

  vec_t  tbl[$];
  out_t  sbq[$];
  string nmq[$];
  out_t  cur;
  int    passed = 0;
  int    total  = 0;

  function automatic out_t act();
    act = {SEL, INCR, Clear, LD_TIME, LD_ALARM, ALM_IDX, AlarmEn, Ring, RingIdx};
  endfunction

  function automatic out_t mk(input logic [3:0] s);
    out_t o;
    o = cur;
    {o.incr, o.clr, o.ldt, o.lda} = s;
    return o;
  endfunction

  task automatic chk(input string n, input out_t a, input out_t e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic step(input string n, input in_t i, input out_t o);
    out_t  e;
    string en;
    {SetTime, SetAlarm, Next, Up, Snooze, Stop, MinTick} = i.b;
    Match = i.m;
    sbq.push_back(o);
    nmq.push_back(n);
    @(posedge Clk);
    #1;
    e  = sbq.pop_front();
    en = nmq.pop_front();
    chk(en, act(), e);
  endtask

  task automatic row(input string n, input logic [6:0] b, input logic [3:0] m, input logic [3:0] s);
    vec_t v;
    v.name = n;
    v.i    = {b, m};
    v.o    = mk(s);
    tbl.push_back(v);
  endtask

  task automatic go(input string n, input logic [6:0] b, input logic [3:0] m, input logic [3:0] s);
    step(n, {b, m}, mk(s));
  endtask

  task automatic prog_slot(input logic [3:0] en_after);
    cur.sel = 2'd0;
    row("a_edit", I_SA | I_NX, 4'h0, S_CLR);
    row("a_rel", I_SA, 4'h0, S_NO);
    cur.sel = 2'd1;
    row("a_next_min", I_SA | I_NX, 4'h0, S_NO);
    row("a_rel", I_SA, 4'h0, S_NO);
    cur.en = en_after;
    row("a_commit", I_SA | I_NX, 4'h0, S_LDA);
    row("a_rel", I_SA, 4'h0, S_NO);
  endtask

  initial begin
    {SetTime, SetAlarm, Next, Up, Snooze, Stop, MinTick} = '0;
    Match = '0;
    Reset = 1'b1;
    #2 Reset = 1'b0;
    #1 chk("reset_state", act(), '0);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1;

    // ---- vector table ----
    cur = '0;
    row("t_enter", I_ST, 4'h0, S_CLR);
    for (int k = 0; k < 3; k++) begin
      row("t_up_hour", I_ST | I_UP, 4'h0, S_INC);
      if (k == 2) row("t_up_held", I_ST | I_UP, 4'h0, S_NO);
      row("t_rel", I_ST, 4'h0, S_NO);
    end
    cur.sel = 2'd1;
    row("t_next_hour", I_ST | I_NX, 4'h0, S_NO);
    row("t_next_held", I_ST | I_NX, 4'h0, S_NO);
    row("t_rel", I_ST, 4'h0, S_NO);
    for (int k = 0; k < 2; k++) begin
      row("t_up_min", I_ST | I_UP, 4'h0, S_INC);
      row("t_rel", I_ST, 4'h0, S_NO);
    end
    cur.sel = 2'd2;
    row("t_next_beats_up", I_ST | I_NX | I_UP, 4'h0, S_NO);
    row("t_rel", I_ST, 4'h0, S_NO);
    row("t_commit", I_ST | I_NX, 4'h0, S_LDT);
    row("t_idle", I_NO, 4'h0, S_NO);
    cur.sel = 2'd0;
    row("t_reenter", I_ST, 4'h0, S_CLR);
    cur.sel = 2'd1;
    row("t_next", I_ST | I_NX, 4'h0, S_NO);
    row("t_cancel", I_NO, 4'h0, S_NO);
    row("t_idle2", I_NO, 4'h0, S_NO);
    cur.sel = 2'd0;
    row("settime_beats_setalarm", I_ST | I_SA, 4'h0, S_CLR);
    row("t_cancel2", I_NO, 4'h0, S_NO);

    row("a_enter", I_SA, 4'h0, S_NO);
    for (int k = 0; k < 5; k++) begin
      cur.idx = cur.idx + 2'd1;
      row("a_up_idx", I_SA | I_UP, 4'h0, S_NO);
      row("a_rel", I_SA, 4'h0, S_NO);
    end
    prog_slot(4'b0010);
    cur.idx = 2'd2;
    row("a_up_idx2", I_SA | I_UP, 4'h0, S_NO);
    row("a_rel", I_SA, 4'h0, S_NO);
    prog_slot(4'b0110);
    cur.en = 4'b0010;
    row("a_stop_disable", I_SA | I_SP, 4'h0, S_NO);
    row("a_rel", I_SA, 4'h0, S_NO);
    prog_slot(4'b0110);
    cur.sel = 2'd0;
    row("a_edit_again", I_SA | I_NX, 4'h0, S_CLR);
    row("a_edit_cancel", I_NO, 4'h0, S_NO);
    row("idle", I_NO, 4'h0, S_NO);

    row("match_no_tick", I_NO, 4'b0110, S_NO);
    row("tick_disabled_slots", I_MT, 4'b1001, S_NO);
    cur.ring = 1'b1;
    cur.ridx = 2'd1;
    row("ring_lowest_slot", I_MT, 4'b0110, S_NO);
    row("ring_hold", I_NO, 4'h0, S_NO);
    cur.ring = 1'b0;
    row("ring_stop", I_SP, 4'h0, S_NO);
    row("idle_rel", I_NO, 4'h0, S_NO);

    cur = '0;
    foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].o);
    cur = tbl[tbl.size()-1].o;

    // ---- snooze limit and auto-timeout ----
    cur.ring = 1'b1;
    cur.ridx = 2'd2;
    go("ring_slot2", I_MT, 4'b0100, S_NO);
    for (int k = 0; k < 3; k++) begin
      cur.ring = 1'b0;
      go("snooze_press", I_SZ, 4'h0, S_NO);
      go("snooze_rel", I_NO, 4'h0, S_NO);
      go("snooze_tick1", I_MT, 4'h0, S_NO);
      go("snooze_gap", I_NO, 4'h0, S_NO);
      cur.ring = 1'b1;
      go("snooze_wake", I_MT, 4'h0, S_NO);
      go("wake_gap", I_NO, 4'h0, S_NO);
    end
    go("snooze_limit_ignored", I_SZ, 4'h0, S_NO);
    go("snooze_rel", I_NO, 4'h0, S_NO);
    for (int t = 1; t <= 10; t++) begin
      if (t == 10) cur.ring = 1'b0;
      go("timeout_tick", I_MT, 4'h0, S_NO);
      go("timeout_gap", I_NO, 4'h0, S_NO);
    end

    // ---- stop beats snooze; new slot during snooze ----
    cur.ring = 1'b1;
    cur.ridx = 2'd1;
    go("ring_slot1", I_MT, 4'b0010, S_NO);
    cur.ring = 1'b0;
    go("stop_beats_snooze", I_SZ | I_SP, 4'h0, S_NO);
    go("rel", I_NO, 4'h0, S_NO);
    cur.ring = 1'b1;
    go("ring_slot1b", I_MT, 4'b0010, S_NO);
    cur.ring = 1'b0;
    go("snooze_again", I_SZ, 4'h0, S_NO);
    go("rel", I_NO, 4'h0, S_NO);
    cur.ring = 1'b1;
    cur.ridx = 2'd2;
    go("snooze_new_slot", I_MT, 4'b0110, S_NO);
    cur.ring = 1'b0;
    go("stop_new_slot", I_SP, 4'h0, S_NO);
    go("rel", I_NO, 4'h0, S_NO);

    // ---- pending match during time edit ----
    cur.sel = 2'd0;
    go("p_edit", I_ST, 4'h0, S_CLR);
    go("p_match_in_edit", I_ST | I_MT, 4'b0010, S_NO);
    go("p_hold", I_ST, 4'h0, S_NO);
    go("p_cancel_idle", I_NO, 4'h0, S_NO);
    cur.ring = 1'b1;
    cur.ridx = 2'd1;
    go("p_ring_no_tick", I_NO, 4'h0, S_NO);
    cur.ring = 1'b0;
    go("p_stop", I_SP, 4'h0, S_NO);
    go("rel", I_NO, 4'h0, S_NO);

    // ---- asynchronous reset mid-ring ----
    cur.ring = 1'b1;
    cur.ridx = 2'd2;
    go("r_ring", I_MT, 4'b0100, S_NO);
    @(negedge Clk);
    {SetTime, SetAlarm, Next, Up, Snooze, Stop, MinTick} = '0;
    Match = '0;
    Reset = 1'b0;
    #1 chk("async_reset_no_edge", act(), '0);
    @(posedge Clk);
    #1 chk("reset_held", act(), '0);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1;
    cur = '0;
    go("post_reset_idle", I_NO, 4'h0, S_NO);
    go("post_reset_tick", I_MT, 4'b1111, S_NO);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl_multi.md
# alarm_ctrl_multi

Control unit for the multi-alarm clock: a registered finite-state machine that sequences time editing, editing of `NUM_ALARMS` independent alarm slots, alarm ringing, snooze with a bounded repeat count, and ring auto-timeout. It sits between the debounced front-panel buttons and the datapath: the edit register, time counters, alarm slot registers and per-slot match comparators. It drives their load, clear and increment strobes.

## Interface
Parameters:
- `NUM_ALARMS`, default 4: number of alarm slots, at least 1. `AW = max(1, $clog2(NUM_ALARMS))`.
- `SNOOZE_MIN`, default 5: snooze length in minutes, at least 1.
- `SNOOZE_MAX`, default 3: maximum snoozes per ring event, at least 0.
- `RING_TIMEOUT_MIN`, default 10: number of minutes of unattended ringing before auto-stop, at least 1.

Ports:
- `Clk` in 1: the single clock. All state and outputs change on its rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `SetTime`, `SetAlarm` in 1: level mode switches.
- `Next`, `Up`, `Snooze`, `Stop` in 1: debounced, synchronous buttons. The block edge-detects them internally.
- `MinTick` in 1: single-cycle pulse once per minute from the timebase.
- `Match` in `NUM_ALARMS`: `Match[i]` = slot i alarm time equals the current time.
- `SEL` out 2: edit field select. 0 = hour, 1 = minute, 2 = day.
- `INCR` out 1: increment the selected edit field.
- `Clear` out 1: clear the edit register.
- `LD_TIME` out 1: load the edit register into the time counters.
- `LD_ALARM` out 1: load the edit register into slot `ALM_IDX`.
- `ALM_IDX` out `AW`: slot being selected or edited.
- `AlarmEn` out `NUM_ALARMS`: per-slot enable register.
- `Ring` out 1: buzzer drive.
- `RingIdx` out `AW`: slot that caused the current ring.

## Operation
- **Reset.** `Reset` low puts the block in state `IDLE`. All outputs are 0, `AlarmEn` is 0, all counters and the pending flag are 0, and edge-detect history is 0. This takes effect immediately, including mid-edit or mid-ring.
- **Buttons.** A button "press" is a sample of 1 whose previous sample was 0. Holding a button produces exactly one press.
- **Strobes.** `INCR`, `Clear`, `LD_TIME` and `LD_ALARM` are single-cycle, registered pulses.

States and transitions:
- **`IDLE`.** Transitions are taken in this priority order:
  - On `MinTick & |(Match & AlarmEn)`, or when the pending flag is set, go to `RING`. `RingIdx` is the lowest qualifying i. Clear the pending flag.
  - Else if `SetTime`, go to `T_EDIT` with `SEL`=0 and pulse `Clear`.
  - Else if `SetAlarm`, go to `A_SEL`.
- **`T_EDIT`** (fields hour → minute → day):
  - `Up` press: pulse `INCR`.
  - `Next` press: advance `SEL`. A `Next` press at `SEL`=2 pulses `LD_TIME` and returns to `IDLE`.
  - `SetTime` low before the commit: go to `IDLE` with no `LD_TIME` (cancel).
- **`A_SEL`:**
  - `Up` press: `ALM_IDX` ← (`ALM_IDX`+1) mod `NUM_ALARMS`.
  - `Stop` press: clear `AlarmEn[ALM_IDX]`.
  - `Next` press: go to `A_EDIT` with `SEL`=0 and pulse `Clear`.
  - `SetAlarm` low: go to `IDLE`.
- **`A_EDIT`** (fields hour → minute only):
  - `Up` press: pulse `INCR`.
  - `Next` press at `SEL`=0: `SEL`=1.
  - `Next` press at `SEL`=1: pulse `LD_ALARM`, set `AlarmEn[ALM_IDX]`, return to `A_SEL`.
  - `SetAlarm` low: cancel to `IDLE` with no load.
- **Matches during edits.** In `T_EDIT`, `A_SEL` and `A_EDIT`, a qualifying `MinTick & Match` sets the pending flag. It is serviced on the first `IDLE` cycle.
- **`RING`.** `Ring`=1. The timeout counter loads `RING_TIMEOUT_MIN` on entry and decrements on each `MinTick`.
  - `Stop` press: go to `IDLE`, `Ring`=0, snooze count reset to 0.
  - `Snooze` press with snooze count < `SNOOZE_MAX`: go to `SNOOZE`, increment the count, load the counter with `SNOOZE_MIN`.
  - `Snooze` press with count = `SNOOZE_MAX`: ignored.
  - Timeout counter reaches 0: same behaviour as a `Stop` press.
- **`SNOOZE`.** `Ring`=0. The counter decrements on `MinTick`; on reaching 0, go to `RING` with the same `RingIdx`.
  - `Stop` press: go to `IDLE` and reset the count.
  - A new qualifying match on a different slot: go to `RING` with the new index and reset the count.
- **Simultaneous events.**
  - `Next` and `Up` pressed in the same cycle: `Next` wins.
  - `Stop` and `Snooze` pressed in the same cycle: `Stop` wins.
  - In `IDLE`, `SetTime` beats `SetAlarm`.
- **Width rules.** The counter is wide enough for `max(SNOOZE_MIN, RING_TIMEOUT_MIN)`. `ALM_IDX` wraps at `NUM_ALARMS`, not at 2^`AW`.

## Timing
- Latency is 1 cycle. An input sampled at edge k is reflected in the state and outputs after edge k.
- Strobes are high for exactly one `Clk` period.
- A press arriving in the cycle of a state transition is evaluated in the old state.
- `Ring` rises the cycle after the triggering `MinTick` is sampled.
- `ALM_IDX`, `SEL` and `AlarmEn` hold their values across `IDLE`. `SEL` resets to 0 on each edit entry.

## Test plan
- **Time edit:** reset, `SetTime`=1, `Up`×3, `Next`, `Up`×2, `Next`, `Next` → `Clear`×1, `INCR`×5, `SEL` sequence 0,1,2, then one `LD_TIME` pulse and `IDLE`.
- **Alarm edit and wrap:** `NUM_ALARMS`=4, `SetAlarm`=1, `Up`×5 → `ALM_IDX`=1. Then `Next`,`Next`,`Next` → `LD_ALARM`, `AlarmEn`=4'b0010.
- **Ring and priority:** `AlarmEn`=4'b0110, `Match`=4'b0110 with `MinTick` → `Ring`=1 next cycle, `RingIdx`=1. Then `Stop` → `Ring`=0.
- **Snooze limit:** `SNOOZE_MIN`=2, `SNOOZE_MAX`=3.
  - Snooze three times → `Ring` reasserts 2 `MinTick`s after each snooze.
  - A 4th `Snooze` press is ignored.
  - After 10 `MinTick`s unattended, `Ring` drops to 0 (auto-stop).
- **Pending match:** qualifying match while in `T_EDIT`, then `SetTime`=0 → `IDLE` for one cycle, then `RING` with no further `MinTick`.
- **Async reset:** `Reset` low mid-`RING` with `AlarmEn`≠0 → `Ring`, `AlarmEn` and all strobes go to 0 without a clock edge. After release, state is `IDLE`.
